marquee_scroller: RTL
=====================

// Module: marquee_scroller
// PURPOSE
// Upstream character source for the HEX5..HEX0 seven-segment decoders.
// Holds an 8-character message, "PAYSANDU" by default, in a register buffer and scrolls it across six digits.
// The message is followed by GAP blank positions. A prescaled tick from CLOCK50 advances the scroll.
// Outputs one 5-bit character code per digit; the downstream per-digit decoder turns each code into segments.
// PARAMETERS
// TICK_DIV    25_000_000  CLOCK50 cycles per scroll step (0.5 s); legal range >= 2
// MSG_LEN     8           message buffer depth in characters
// GAP         2           blank positions appended after the message in the scroll ring
// HOLD_TICKS  2           ticks paused after each wrap; 0 = no pause
// N_DIGITS    6           number of display digits
// CODE_W      5           character code width
// PORTS
// CLOCK50      in   1                  system clock, 50 MHz
// reset        in   1                  synchronous, active-high reset
// enable       in   1                  1 = scroll; 0 = freeze display
// dir          in   1                  0 = text moves left (pos+1); 1 = text moves right (pos-1)
// wr_en        in   1                  message write strobe
// wr_addr      in   $clog2(MSG_LEN)    message buffer index
// wr_data      in   CODE_W             character code to write
// digit_codes  out  N_DIGITS*CODE_W    [CODE_W*i +: CODE_W] drives HEXi
// step         out  1                  1-cycle pulse, registered, in the cycle after pos changes
// wrap         out  1                  1-cycle pulse, coincident with step, when pos wraps
// BEHAVIOUR
// Codes: 0x00-0x09 digits; A=0x0A, D=0x0D, S=0x05, P=0x10, Y=0x11, N=0x12, U=0x13; blank=0x1F.
// Scroll ring: length L=MSG_LEN+GAP. Ring index r<MSG_LEN yields msg[r]; any other index yields blank.
// Display mapping: HEX(N_DIGITS-1-j) = ring[(pos+j) mod L] for j=0..N_DIGITS-1; HEX5 is leftmost.
// digit_codes is a combinational decode of the registered pos and msg, so it has zero latency from those registers.
// Reset values:
//  - msg = P,A,Y,S,A,N,D,U (msg[0]=P); pos=0; prescaler=0; state=IDLE; step=0; wrap=0.
//  - After reset the display reads HEX5..HEX0 = P A Y S A N.
// Prescaler: counts 0..TICK_DIV-1 in RUN and HOLD. tick = 1 when the count equals TICK_DIV-1; the count then returns to 0.
// FSM:
//  - IDLE: prescaler held at 0; pos held. Go to RUN when enable=1.
//  - RUN: on tick, pos <= dir ? (pos==0 ? L-1 : pos-1) : (pos==L-1 ? 0 : pos+1).
//    On a wrap edge (L-1->0, or 0->L-1) go to HOLD if HOLD_TICKS>0; otherwise stay in RUN.
//  - HOLD: count HOLD_TICKS ticks with pos frozen, then go to RUN. The hold counter clears on entry.
//  - Any state: enable=0 goes to IDLE on the next edge; pos and msg are retained; prescaler and hold count clear.
// Re-enable: the first step comes a full TICK_DIV cycles after entering RUN; there is no partial tick.
// dir is sampled only on a tick; changing it between ticks has no other effect.
// Writes: when wr_en=1, msg[wr_addr] <= wr_data in any state, including IDLE and reset-release+1.
//  - The write is visible on digit_codes the cycle after the edge.
//  - A write on the same edge as a step: both take effect; the display shows the new pos with the new data.
//  - wr_addr >= MSG_LEN is ignored; no buffer entry changes.
// reset has priority over every input, including wr_en in the same cycle.
// Arithmetic: pos is $clog2(L) bits wide and never leaves 0..L-1. All modulo operations use compare-and-select; no divider.
// TESTING (TICK_DIV=4, HOLD_TICKS=2 unless noted)
// 1 reset, enable=0 for 20 cycles -> HEX5..0 = 10,0A,11,05,0A,12; step never pulses.
// 2 enable=1, dir=0 -> step every 4 cycles; after 1 step HEX5..0 = 0A,11,05,0A,12,0D.
//   After 4 steps HEX0 = 1F (gap); after 10 steps wrap=1, pos=0.
// 3 wrap from test 2 -> no step for 8 cycles (2 ticks of hold), then steps resume at a 4-cycle period.
// 4 from reset with dir=1 -> first step gives pos=9, wrap=1, HEX5 = 1F, HEX4 = 10.
//   Toggle dir mid-tick -> the next step follows the new dir.
// 5 wr_en, addr=0, data=0x07 on a step edge -> next cycle shows the shifted pos, and ring slot 0 reads 07.
//   addr >= MSG_LEN (MSG_LEN=6 variant) -> no change.
// 6 enable dropped mid-count, then raised -> no step for exactly 4 cycles after re-entering RUN.
//   reset asserted in HOLD -> the state of test 1 in the following cycle.

Source files
------------

// File: rtl/marquee_scroller_if.sv
// Control, message-write and display signals between the scroller and its user.
// The master side drives enable/dir/writes; the slave (the scroller) returns the
// per-digit character codes and the step/wrap pulses.
interface marquee_scroller_if #(
    parameter int MSG_LEN  = 8,
    parameter int N_DIGITS = 6,
    parameter int CODE_W   = 5
);
    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    logic                         enable;
    logic                         dir;
    logic                         wr_en;
    logic [AW-1:0]                wr_addr;
    logic [CODE_W-1:0]            wr_data;
    logic [N_DIGITS*CODE_W-1:0]   digit_codes;
    logic                         step;
    logic                         wrap;

    modport master (
        output enable, dir, wr_en, wr_addr, wr_data,
        input  digit_codes, step, wrap
    );

    modport slave (
        input  enable, dir, wr_en, wr_addr, wr_data,
        output digit_codes, step, wrap
    );
endinterface

// File: rtl/marquee_scroller.sv
// Scrolling message source for a row of seven-segment digits.
// A register buffer holds the message; a ring of MSG_LEN message slots plus GAP
// blanks is scrolled one position per prescaled tick, with an optional pause
// after each wrap. digit_codes is a pure decode of the registered pos and msg.
module marquee_scroller #(
    parameter int TICK_DIV   = 25_000_000,
    parameter int MSG_LEN    = 8,
    parameter int GAP        = 2,
    parameter int HOLD_TICKS = 2,
    parameter int N_DIGITS   = 6,
    parameter int CODE_W     = 5
) (
    input  logic              CLOCK50,
    input  logic              reset,
    marquee_scroller_if.slave bus
);
    localparam int L     = MSG_LEN + GAP;
    localparam int PSW   = (L > 1) ? $clog2(L) : 1;
    localparam int PW    = $clog2(TICK_DIV);
    localparam int HW    = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam int IW    = $clog2(L + N_DIGITS);
    localparam int AW    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int WRAPS = (N_DIGITS - 1) / L + 1;

    localparam logic [PSW-1:0]    POS_LAST   = PSW'(L - 1);
    localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0]     HOLD_LAST  = (HOLD_TICKS > 0) ? HW'(HOLD_TICKS - 1) : '0;
    localparam logic [IW-1:0]     RING_LEN   = IW'(L);
    localparam logic [AW:0]       MSG_LEN_C  = (AW + 1)'(MSG_LEN);
    localparam logic [CODE_W-1:0] BLANK      = '1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t            state_q, state_d;
    logic [PSW-1:0]    pos_q, pos_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              step_q, step_d;
    logic              wrap_q, wrap_d;
    logic              tick;
    logic [CODE_W-1:0] msg [MSG_LEN];
    logic [N_DIGITS*CODE_W-1:0] codes;

    // Power-on message "PAYSANDU"; slots past the text start blank.
    function automatic logic [CODE_W-1:0] default_char(input int i);
        case (i)
            0:       return CODE_W'(5'h10);
            1:       return CODE_W'(5'h0A);
            2:       return CODE_W'(5'h11);
            3:       return CODE_W'(5'h05);
            4:       return CODE_W'(5'h0A);
            5:       return CODE_W'(5'h12);
            6:       return CODE_W'(5'h0D);
            7:       return CODE_W'(5'h13);
            default: return BLANK;
        endcase
    endfunction

    assign tick = (presc_q == PRESC_LAST);

    // State, position, prescaler, hold count and the registered pulses.
    always_ff @(posedge CLOCK50) begin
        if (reset) begin
            state_q <= IDLE;
            pos_q   <= '0;
            presc_q <= '0;
            hold_q  <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            presc_q <= presc_d;
            hold_q  <= hold_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next-state logic: prescaler, scroll step with wrap detection, post-wrap pause.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        presc_d = presc_q;
        hold_d  = hold_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            presc_d = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                    presc_d = '0;
                    hold_d  = '0;
                end
                RUN: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        step_d = 1'b1;
                        if (bus.dir) begin
                            wrap_d = (pos_q == '0);
                            pos_d  = wrap_d ? POS_LAST : pos_q - 1'b1;
                        end else begin
                            wrap_d = (pos_q == POS_LAST);
                            pos_d  = wrap_d ? '0 : pos_q + 1'b1;
                        end
                        if (wrap_d && HOLD_TICKS > 0) begin
                            state_d = HOLD;
                            hold_d  = '0;
                        end
                    end
                end
                HOLD: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = RUN;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Message buffer: reset to the default text; out-of-range writes are dropped.
    always_ff @(posedge CLOCK50) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) msg[i] <= default_char(i);
        end else if (bus.wr_en && ({1'b0, bus.wr_addr} < MSG_LEN_C)) begin
            msg[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Display decode: digit j from the left shows ring slot (pos+j) mod L.
    always_comb begin : decode
        logic [IW-1:0]     idx;
        logic [CODE_W-1:0] ch;
        codes = '1;
        for (int j = 0; j < N_DIGITS; j++) begin
            idx = IW'(pos_q) + IW'(j);
            for (int w = 0; w < WRAPS; w++) begin
                if (idx >= RING_LEN) idx = idx - RING_LEN;
            end
            ch = BLANK;
            for (int k = 0; k < MSG_LEN; k++) begin
                if (idx == IW'(k)) ch = msg[k];
            end
            codes[CODE_W*(N_DIGITS-1-j) +: CODE_W] = ch;
        end
    end

    assign bus.digit_codes = codes;
    assign bus.step        = step_q;
    assign bus.wrap        = wrap_q;
endmodule
